// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory arbiter.
// Owner encodings tag the port that owns the response due next cycle.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2,
    OwnDw   = 2'd3  // store ack: data port owns the response, rdata forced to 0
  } owner_e;

  // Read latency of the memory macro, in cycles.
  localparam int unsigned MEM_RD_LAT = 1;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating streak counter used to bound consecutive data grants while a fetch waits.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : count one more data grant (saturates at Max)
//   clr_i         : clear to zero (has priority over inc_i)
//   at_max_o      : count has reached Max
module arb_streak_counter #(
  parameter int unsigned Max = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned W = $clog2(Max + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(Max));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between the fetch port and the
// load/store port. At most one grant per cycle; the response returns one cycle later
// to the owner recorded at grant time.
// Ports:
//   clock, reset_n                     : clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt           : fetch request and same-cycle grant
//   if_rvalid/if_rdata                 : fetch response (cycle after grant)
//   d_req/d_we/d_be/d_addr/d_wdata     : load/store request
//   d_gnt, d_rvalid/d_rdata            : data grant and response (0 data for store acks)
//   mem_en/we/be/addr/wdata, mem_rdata : memory macro interface
//   stall                              : fetch waiting, core holds PC
//   conflict_cnt                       : saturating count of cycles with both requests
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic [CNT_W-1:0]    conflict_cnt
);

  owner_e owner_q, owner_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic streak_at_max;
  logic fetch_wins;

  // Fetch wins when alone, or when data has used up its streak allowance.
  assign fetch_wins = if_req && (!d_req || streak_at_max);

  // Grants are gated by reset_n so nothing reaches the memory while in reset.
  assign if_gnt = reset_n && fetch_wins;
  assign d_gnt  = reset_n && d_req && !fetch_wins;
  assign stall  = if_req && !if_gnt;

  arb_streak_counter #(
    .Max(MAX_DATA_STREAK)
  ) u_streak (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .inc_i   (d_gnt && if_req),
    .clr_i   (if_gnt || !if_req),
    .at_max_o(streak_at_max)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OwnNone;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
      owner_d  = OwnIf;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_d   = d_we ? OwnDw : OwnD;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (if_req && d_req && (conflict_q != '1)) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OwnNone;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;

  assign if_rvalid = (owner_q == OwnIf);
  assign d_rvalid  = (owner_q == OwnD) || (owner_q == OwnDw);
  assign if_rdata  = (owner_q == OwnIf) ? mem_rdata : '0;
  assign d_rdata   = (owner_q == OwnD) ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a memory model answers mem_* accesses,
// expected responses are queued at issue time and a monitor compares them on rvalid.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic [3:0]    conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  always #5 clock = ~clock;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(4), .CNT_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .conflict_cnt(conflict_cnt)
  );

  // Memory model: 1024 words, word i preloaded with {16'hC0DE, i}.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = '0;
  assign mem_rdata = rd_q;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
  end

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        rd_q <= 32'hBAD0_BAD0;  // garbage on write cycles must never reach d_rdata
      end else begin
        rd_q <= mem[mem_addr[11:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response against the per-port expectation queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL if_unexpected: got if_rvalid=1 expected no response (t=%0t)", $time);
        end else begin
          chk("if_rdata", if_rdata, if_q.pop_front());
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_unexpected: got d_rvalid=1 expected no response (t=%0t)", $time);
        end else begin
          chk("d_rdata", d_rdata, d_q.pop_front());
        end
        if (!if_rvalid) chk("if_rdata_idle", if_rdata, 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset: requests present, but nothing may be granted.
    if_req = 1'b1; d_req = 1'b1;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 1: fetch only.
    for (int k = 0; k < 3; k++) begin
      cyc();
      if_req = 1'b1; if_addr = 32'(4 * k);
      if_q.push_back(32'hC0DE_0000 + 32'(k));
      #1;
      chk("t1_if_gnt", 32'(if_gnt), 1);
      chk("t1_mem_be", 32'(mem_be), 32'hF);
      chk("t1_mem_addr", mem_addr, 32'(4 * k));
      chk("t1_stall", 32'(stall), 0);
    end
    cyc(); if_req = 1'b0;
    #1 chk("t1_idle_en", 32'(mem_en), 0);

    // 2: load vs fetch in the same cycle.
    cyc();
    if_req = 1'b1; if_addr = 32'h10; if_q.push_back(32'hC0DE_0004);
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_q.push_back(32'hC0DE_0040);
    #1;
    chk("t2_d_gnt", 32'(d_gnt), 1);
    chk("t2_if_gnt", 32'(if_gnt), 0);
    chk("t2_stall", 32'(stall), 1);
    cyc(); d_req = 1'b0;
    #1;
    chk("t2_if_gnt2", 32'(if_gnt), 1);
    chk("t2_stall2", 32'(stall), 0);
    cyc(); if_req = 1'b0;
    #1 chk("t2_conflict", 32'(conflict_cnt), 1);

    // 3: starvation bound, four data grants then the fetch.
    if_q.push_back(32'hC0DE_0008);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if_req = 1'b1; if_addr = (k <= 4) ? 32'h20 : 32'h24;
      d_req = 1'b1; d_addr = (k < 4) ? 32'h104 + 32'(4 * k) : 32'h114;
      if (k < 4) d_q.push_back(32'hC0DE_0041 + 32'(k));
      if (k == 5) begin
        d_q.push_back(32'hC0DE_0045);
        if_q.push_back(32'hC0DE_0009);
      end
      #1;
      chk("t3_d_gnt", 32'(d_gnt), (k != 4) ? 1 : 0);
      chk("t3_if_gnt", 32'(if_gnt), (k == 4) ? 1 : 0);
      chk("t3_stall", 32'(stall), (k != 4) ? 1 : 0);
    end
    cyc(); d_req = 1'b0;
    #1 chk("t3_if_gnt_last", 32'(if_gnt), 1);
    cyc(); if_req = 1'b0;
    #1 chk("t3_conflict", 32'(conflict_cnt), 7);

    // 4: partial store then reload.
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    d_q.push_back(32'h0);
    #1;
    chk("t4_d_gnt", 32'(d_gnt), 1);
    chk("t4_mem_we", 32'(mem_we), 1);
    chk("t4_mem_be", 32'(mem_be), 32'h3);
    chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    d_we = 1'b0; d_be = 4'h0; d_wdata = '0;
    d_q.push_back(32'hC0DE_BEEF);
    #1;
    chk("t4_ld_gnt", 32'(d_gnt), 1);
    chk("t4_ld_we", 32'(mem_we), 0);
    cyc(); d_req = 1'b0;
    #1 chk("t4_conflict", 32'(conflict_cnt), 7);

    // 5: reset while a load is granted; its response must be dropped.
    cyc();
    d_req = 1'b1; d_addr = 32'h100;
    #1 chk("t5_d_gnt", 32'(d_gnt), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(d_gnt), 0);
    chk("t5_rst_en", 32'(mem_en), 0);
    chk("t5_rst_conflict", 32'(conflict_cnt), 0);
    d_req = 1'b0;
    cyc();
    chk("t5_rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    @(negedge clock); reset_n = 1'b1;
    cyc();
    chk("t5_post_rvalid", 32'(d_rvalid), 0);
    d_req = 1'b1; d_addr = 32'h104; d_q.push_back(32'hC0DE_0041);
    #1 chk("t5_post_gnt", 32'(d_gnt), 1);
    cyc(); d_req = 1'b0;

    // 6: continuous conflict, grant pattern d,d,d,d,if and counter saturation.
    for (int k = 0; k < 20; k++) begin
      cyc();
      if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h100;
      if (k % 5 == 4) if_q.push_back(32'hC0DE_0004);
      else d_q.push_back(32'hC0DE_0040);
      #1;
      chk("t6_if_gnt", 32'(if_gnt), (k % 5 == 4) ? 1 : 0);
      chk("t6_d_gnt", 32'(d_gnt), (k % 5 == 4) ? 0 : 1);
    end
    cyc(); if_req = 1'b0; d_req = 1'b0;
    #1 chk("t6_conflict_sat", 32'(conflict_cnt), 32'hF);

    repeat (3) cyc();
    chk("drain_if_q", 32'(if_q.size()), 0);
    chk("drain_d_q", 32'(d_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
